// File: rtl/ascon_permutation_core.sv
// Iterative Ascon-p[rnd] permutation core: p_C, p_S, p_L per round.
// Macro ASCON_PERM_UNROLL2_EN applies two rounds per RUN cycle.
package ascon_pkg;
    typedef logic [3:0] rnd_t;
    typedef logic [4:0][63:0] ascon_state_t;
endpackage

module constant_addition_layer
    import ascon_pkg::*;
(
    input  ascon_state_t state_i,
    input  rnd_t         rnd_i,
    output ascon_state_t state_o
);
    logic [7:0] c;

    // c_k = {3-k, k-4} in nibbles, e.g. c4 = 0xf0, c8 = 0xb4
    assign c = {4'd3 - rnd_i, rnd_i - 4'd4};

    // XOR the round constant into the low byte of x2
    always_comb begin
        state_o = state_i;
        state_o[2][7:0] = state_i[2][7:0] ^ c;
    end
endmodule

module ascon_permutation_core
    import ascon_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    output logic         ready_o,
    input  rnd_t         rounds_i,
    input  ascon_state_t state_i,
    output logic         valid_o,
    input  logic         ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    ascon_state_t st_q, st_d;
    rnd_t         nr_q, nr_d;
    rnd_t         i_q, i_d;
    rnd_t         nr_in;
    rnd_t         rnd0;
    ascon_state_t pc0, r0, rnd_out;
    logic         accept;
    logic         last;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic ascon_state_t sbox_layer(input ascon_state_t s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
        t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic ascon_state_t lin_layer(input ascon_state_t s);
        ascon_state_t o;
        o[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
        o[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
        o[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
        o[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
        o[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
        return o;
    endfunction

    assign nr_in  = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
    assign rnd0   = 4'(5'd16 - {1'b0, nr_q} + {1'b0, i_q});
    assign ready_o = (fsm_q == IDLE) || ((fsm_q == DONE) && ready_i);
    assign accept  = start_i && ready_o;
    assign valid_o = (fsm_q == DONE);
    assign busy_o  = (fsm_q == RUN);
    assign state_o = st_q;

    constant_addition_layer u_pc0 (
        .state_i(st_q),
        .rnd_i  (rnd0),
        .state_o(pc0)
    );

    assign r0 = lin_layer(sbox_layer(pc0));

`ifdef ASCON_PERM_UNROLL2_EN
    localparam rnd_t STEP = 4'd2;
    rnd_t         rnd1;
    ascon_state_t pc1, r1;

    assign rnd1 = rnd0 + 4'd1;

    constant_addition_layer u_pc1 (
        .state_i(r0),
        .rnd_i  (rnd1),
        .state_o(pc1)
    );

    assign r1 = lin_layer(sbox_layer(pc1));
    // an odd round count leaves a single round for the final edge
    assign rnd_out = ({1'b0, i_q} + 5'd1 < {1'b0, nr_q}) ? r1 : r0;
    assign last = ({1'b0, i_q} + 5'd2 >= {1'b0, nr_q});
`else
    localparam rnd_t STEP = 4'd1;
    assign rnd_out = r0;
    assign last = (i_q == nr_q - 4'd1);
`endif

    // next-state: sequence rounds, accept requests in IDLE or draining DONE
    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        nr_d  = nr_q;
        i_d   = i_q;
        unique case (fsm_q)
            IDLE: ;
            RUN: begin
                st_d = rnd_out;
                i_d  = i_q + STEP;
                if (last) fsm_d = DONE;
            end
            DONE: if (ready_i) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        if (accept) begin
            st_d  = state_i;
            nr_d  = nr_in;
            i_d   = '0;
            fsm_d = (nr_in == 4'd0) ? DONE : RUN;
        end
    end

    // state registers, cleared by asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            nr_q  <= '0;
            i_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            nr_q  <= nr_d;
            i_q   <= i_d;
        end
    end
endmodule

// File: tb/tb_ascon_permutation_core.sv
// Randomized bench for ascon_permutation_core against a table-driven
// software Ascon-p model.
module tb_ascon_permutation_core;
    import ascon_pkg::*;

`ifdef ASCON_PERM_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    localparam logic [7:0] RC [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    logic         clk_i = 0;
    logic         rst_ni = 0;
    logic         start_i = 0;
    logic         ready_o;
    rnd_t         rounds_i = '0;
    ascon_state_t state_i = '0;
    logic         valid_o;
    logic         ready_i = 0;
    ascon_state_t state_o;
    logic         busy_o;

    int checks = 0;
    int failures = 0;

    ascon_permutation_core dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .ready_o (ready_o),
        .rounds_i(rounds_i),
        .state_i (state_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .state_o (state_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [319:0] got,
                         input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [4:0] v, y;
        int nr;
        nr = (r > 12) ? 12 : r;
        for (int k = 0; k < 5; k++) x[k] = s[64*k +: 64];
        for (int rd = 0; rd < nr; rd++) begin
            x[2][7:0] = x[2][7:0] ^ RC[16 - nr + rd];
            for (int b = 0; b < 64; b++) begin
                v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                y = SBOX[v];
                {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = y;
            end
            for (int k = 0; k < 5; k++)
                x[k] = x[k] ^ ror(x[k], ROT_A[k]) ^ ror(x[k], ROT_B[k]);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    // one request from IDLE: latency, constant index sequence, result
    task automatic run_req(input logic [319:0] s, input int r);
        int nr, lat, k;
        logic [319:0] exp;
        nr = (r > 12) ? 12 : r;
        exp = ref_perm(s, r);
        @(negedge clk_i);
        state_i = s; rounds_i = 4'(r); start_i = 1;
        check("ready_idle", ready_o, 1);
        @(posedge clk_i); #1;
        start_i = 0; state_i = rand_state(); rounds_i = 4'($urandom);
        lat = 0; k = 0;
        while (!valid_o && lat < 40) begin
            if (busy_o) begin
                check("rnd_idx", dut.u_pc0.rnd_i, 16 - nr + k * STEP);
                k++;
            end
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", lat, (nr + STEP - 1) / STEP);
        check("result", state_o, exp);
        check("busy_cycles", k, (nr + STEP - 1) / STEP);
        ready_i = 1;
        @(posedge clk_i); #1;
        ready_i = 0;
        check("consumed", valid_o, 0);
    endtask

    task automatic backpressure();
        logic [319:0] s, exp;
        int n;
        s = rand_state();
        exp = ref_perm(s, 6);
        @(negedge clk_i);
        state_i = s; rounds_i = 4'd6; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
        n = 0;
        while (!valid_o && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("bp_valid", valid_o, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            start_i = (c % 2 == 0);
            state_i = rand_state();
            rounds_i = 4'd0;
            check("bp_state", state_o, exp);
            check("bp_ready", ready_o, 0);
            check("bp_valid_hold", valid_o, 1);
        end
        @(negedge clk_i);
        start_i = 0; ready_i = 1;
        @(posedge clk_i); #1;
        ready_i = 0;
        check("bp_drained", {valid_o, busy_o}, 2'b00);
    endtask

    task automatic back_to_back();
        logic [319:0] exp_q [$];
        logic [319:0] exp;
        int got, last_cyc, lat;
        logic acc;
        lat = (3 + STEP - 1) / STEP;
        got = 0; last_cyc = -1;
        ready_i = 1; rounds_i = 4'd3; state_i = rand_state(); start_i = 1;
        for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
            @(negedge clk_i);
            if (valid_o) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check("b2b_result", state_o, exp);
                if (last_cyc >= 0) check("b2b_gap", cyc - last_cyc, lat + 1);
                last_cyc = cyc;
                got++;
            end
            if (got == 5) start_i = 0;
            acc = start_i && ready_o;
            if (acc) exp_q.push_back(ref_perm(state_i, 3));
            @(posedge clk_i); #1;
            if (acc) state_i = rand_state();
        end
        check("b2b_count", got, 5);
        ready_i = 0;
        check("b2b_drained", valid_o, 0);
    endtask

    initial begin
        #12;
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_state", state_o, '0);
        @(negedge clk_i);
        rst_ni = 1;

        run_req({5{64'h0123456789abcdef}}, 0);
        check("pass_through", state_o, {5{64'h0123456789abcdef}});
        run_req(rand_state(), 12);
        run_req(rand_state(), 8);
        run_req(rand_state(), 15);
        for (int t = 0; t < 20; t++) begin
            int pick;
            pick = $urandom_range(0, 3);
            run_req(rand_state(), (pick == 0) ? 1 : (pick == 1) ? 6 :
                                  (pick == 2) ? 8 : 12);
        end

        backpressure();

        @(negedge clk_i);
        state_i = rand_state(); rounds_i = 4'd12; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
        repeat (5) @(posedge clk_i);
        #1;
        rst_ni = 0;
        #1;
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_state", state_o, '0);
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1;
        run_req(rand_state(), 12);

        back_to_back();
        run_req(rand_state(), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ascon_permutation_core.md
# ascon_permutation_core

Iterative Ascon-p[rnd] permutation engine (NIST SP 800-232). It accepts a 320-bit state through a valid/ready handshake and applies 0–12 rounds. Each round is p_C (constant_addition_layer), then p_S, then p_L. The result is presented through an output valid/ready handshake. It is the round sequencer that drives `rnd_i` of constant_addition_layer and sits beneath the AEAD/hash/XOF mode controllers.

## Interface
- No parameters. Round-count behaviour is fixed by ports; unrolling is set by macro (see Configuration).
- `clk_i` input 1: clock, rising-edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `start_i` input 1: input valid; the request is accepted on a rising edge where `start_i && ready_o`.
- `ready_o` output 1: core can accept a request this cycle.
- `rounds_i` input 4 (`rnd_t`): number of rounds nr. Sampled only on acceptance.
- `state_i` input 320 (`ascon_state_t`): input state S. `state_i[0]` is x0. Sampled only on acceptance.
- `valid_o` output 1: `state_o` holds a completed permutation result.
- `ready_i` input 1: downstream consumes the result on a rising edge where `valid_o && ready_i`.
- `state_o` output 320 (`ascon_state_t`): result register. Holds its value until the next acceptance.
- `busy_o` output 1: high in RUN.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `ready_o`=1.
  - On acceptance: load the state register with `state_i`, load nr = min(`rounds_i`, 12), clear round counter i to 0.
  - If nr=0, go to DONE. Otherwise go to RUN.
- **RUN**
  - Each edge applies round i to the state register and increments i.
  - Round i uses constant index 16−nr+i (SP 800-232 table c0..c15). This gives c4=0xf0 for the first of 12 rounds and c8=0xb4 for the first of 8 rounds.
  - The index is driven onto an instantiated constant_addition_layer `rnd_i`.
  - When i reaches nr−1 on an edge, that edge performs the final round and moves to DONE.
- **DONE**
  - `valid_o`=1 and `state_o` is stable.
  - On `ready_i`, go to IDLE.
  - Back-to-back: `ready_o` = IDLE || (DONE && `ready_i`). The combinational path from `ready_i` to `ready_o` is intentional.
  - If `start_i` is also high in that same cycle, the core accepts the new request in the same edge and moves directly to RUN, or to DONE if nr=0.
- **Round count**
  - `rounds_i`>12 saturates to 12.
  - `rounds_i`=0 is a pass-through: `state_o` equals `state_i`.
- **Request handling**
  - `start_i` is ignored in RUN and in DONE without `ready_i`. There is no queuing.
  - Inputs other than `start_i` are don't-care outside acceptance.
- **p_S**
  - Bitsliced 5-bit Ascon S-box over 64 columns, x0 as MSB.
  - Table: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d 11 18 10 0c 01 19 16 0a 0f 17.
- **p_L** uses right rotations:
  - x0 ^= (x0>>>19) ^ (x0>>>28)
  - x1 ^= >>>61, >>>39
  - x2 ^= >>>1, >>>6
  - x3 ^= >>>10, >>>17
  - x4 ^= >>>7, >>>41

## Timing
- **Reset** (`rst_ni` low, asynchronous):
  - FSM goes to IDLE, the state register is 0 and i=0.
  - Outputs: `valid_o`=0, `busy_o`=0, `state_o`=0. `ready_o`=1 because it is decoded from IDLE.
  - A reset asserted mid-RUN or in DONE aborts the operation and discards the result.
- **Latency** from the acceptance edge to `valid_o` high:
  - nr edges, so 12 cycles for nr=12 and 8 for nr=8.
  - For nr=0, `valid_o` is high immediately after the acceptance edge.
- **Throughput:** one request per nr+1 cycles with `ready_i` tied high. Back-to-back acceptance removes any IDLE bubble.
- **Stalls:** `valid_o` stays high and `state_o` stays stable for as long as `ready_i` is low.
- `busy_o` is high exactly nr cycles per request with nr≥1.

## Configuration
- Macro: `ASCON_PERM_UNROLL2_EN`.
- **Defined:** two rounds are applied per RUN edge, using two cascaded round instances with indices 16−nr+i and 16−nr+i+1, and i increments by 2.
  - If nr is odd, the final RUN edge applies only one round.
  - Latency is ceil(nr/2) edges: 6 for nr=12, 4 for nr=8, 1 for nr=1.
- **Undefined:** one round per edge as described above.
- Results are bit-identical in both builds.

## Test plan
- **Reset mid-run:** `rounds_i`=12, random S, pulse `rst_ni` low at RUN cycle 5. Required: immediately `valid_o`=0, `state_o`=0, `ready_o`=1. A fresh request afterwards completes correctly.
- **Latency and golden model:** 20 random S with `rounds_i`∈{1,6,8,12}, `ready_i`=1. Required: `valid_o` rises exactly nr edges after acceptance (ceil(nr/2) with `ASCON_PERM_UNROLL2_EN`), and `state_o` equals the bench software Ascon-p model.
- **Pass-through and saturation:**
  - `rounds_i`=0 with S=0x0123…: `state_o`==S, `valid_o` high one cycle after acceptance.
  - `rounds_i`=15: result equals the nr=12 result, with 12-cycle latency.
- **Constant sequencing:** probe the p_C `rnd_i` during RUN. Required sequence for nr=12 is 4,5,…,15; for nr=8 it is 8,…,15.
- **Backpressure:** hold `ready_i`=0 for 10 cycles after `valid_o`. Required: `state_o` stable, `ready_o`=0, and `start_i` pulses ignored.
- **Back-to-back:** `ready_i`=1 and `start_i`=1 continuously with new S each acceptance. Required: a new acceptance on every DONE edge, with no IDLE cycle between results.
